oam_dma: RTL and testbench
==========================

OAM_DMA -- requirements
Module: oam_dma

Interface
REQ-001 clock  in  1  system clock; all state updates on rising edge.
REQ-002 reset  in  1  synchronous, active-high reset.
REQ-003 ce  in  1  CPU clock-enable pulse, one clock wide; the interval between pulses is one "CPU cycle", at least 2 clocks.
REQ-004 cpu_a  in  16  CPU address bus.
REQ-005 cpu_o  in  8  CPU write data.
REQ-006 cpu_w  in  1  CPU write strobe.
REQ-007 oam_base  in  8  current OAMADDR ($2003 value), supplied by the PPU.
REQ-008 halt  out  1  stalls the CPU while high; the CPU ce is gated by ~halt.
REQ-009 busy  out  1  transfer in progress; equals halt.
REQ-010 prga  out  16  PRG read address; prgi is valid one clock after prga changes.
REQ-011 prgi  in  8  PRG read data.
REQ-012 oama  out  8  OAM write address.
REQ-013 oamd  out  8  OAM write data.
REQ-014 oamw  out  1  OAM write strobe.

Function
REQ-015 Trigger: when idle, ce=1, cpu_w=1 and cpu_a=16'h4014, latch page<=cpu_o, set idx<=0, enter HALT and raise halt on the same edge.
REQ-016 cpu_w without ce, and writes to any other address, are ignored.
REQ-017 Parity flag odd toggles on every ce pulse, whatever the state.
REQ-018 States: IDLE, HALT, ALIGN, RD, WR; transitions occur only on clocks with ce=1.
REQ-019 HALT -> ALIGN if odd=1 at that ce, else HALT -> RD.
REQ-020 ALIGN -> RD unconditionally.
REQ-021 RD: prga={page,idx} is held stable for the whole cycle; at the ending ce, buf<=prgi and go to WR.
REQ-022 WR: oama=oam_base+idx (mod 256) and oamd=buf are held stable for the whole cycle.
REQ-023 WR: oamw is high for exactly the one clock coinciding with the ending ce; then idx<=idx+1.
REQ-024 WR with idx=255 -> IDLE, with halt and busy dropping on the same edge; otherwise WR -> RD.
REQ-025 Total halt length is 513 CPU cycles when HALT starts even, and 514 when it starts odd.
REQ-026 Exactly 256 oamw pulses occur per transfer.
REQ-027 OAM address wraps: with oam_base=8'hF0, byte 16 of the transfer is written to oama=8'h00.
REQ-028 oam_base is sampled continuously, not latched; the PPU guarantees it is stable during a transfer.
REQ-029 A $4014 write seen while busy is ignored; no restart and no page change.
REQ-030 Page 8'hFF reads 16'hFF00-16'hFFFF with no carry out of the page.
REQ-031 Outside RD, prga=16'h0000; outside WR, oamw=0.

Reset
REQ-032 Reset is synchronous and active-high; it overrides ce and any trigger on the same clock.
REQ-033 Reset values: state=IDLE, halt=0, busy=0, oamw=0, prga=0, oama=0, oamd=0, page=0, idx=0, buf=0, odd=0.
REQ-034 Reset mid-transfer aborts immediately: no further oamw, and halt=0 on the following clock.

Structure
REQ-035 Shared package dendy_pkg holds:
- constant DMA_REG=16'h4014
- state enum {IDLE, HALT, ALIGN, RD, WR}
- constant OAM_SIZE=256
REQ-036 The block is a single module with no sub-modules; the parity flag and byte counter are local registers.

Verification
REQ-037 Even-start trigger: ce every 4 clocks, write 8'h02 to $4014, PRG[$0200+i]=i^8'h5A, oam_base=0 -> OAM[i]=i^8'h5A for all 256 bytes; halt high for exactly 513 ce pulses.
REQ-038 Odd-start trigger: same stimulus but with odd=1 at the HALT ce -> halt lasts 514 ce pulses; OAM contents identical to REQ-037.
REQ-039 Wrap-around: oam_base=8'hF0, page 8'h03 -> PRG $0310 is written to OAM[8'h00], and PRG $030F to OAM[8'hFF].
REQ-040 Busy write: write $4014=8'h07 at cycle 100 of a transfer -> ignored; all 256 reads stay in page 8'h02.
REQ-041 Reset mid-transfer: assert reset after 40 oamw pulses -> zero further oamw, halt=0 one clock later; a subsequent $4014 write starts a clean 513/514-cycle transfer.
REQ-042 Non-ce trigger: cpu_w=1 with cpu_a=$4014 on clocks where ce=0 only -> state stays IDLE and halt stays 0.

Source files
------------

// File: rtl/dendy_pkg.sv
// rtl/dendy_pkg.sv - shared constants and state encoding for the OAM DMA block
package dendy_pkg;

    localparam logic [15:0] DMA_REG  = 16'h4014;
    localparam int          OAM_SIZE = 256;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        HALT  = 3'd1,
        ALIGN = 3'd2,
        RD    = 3'd3,
        WR    = 3'd4
    } dma_state_e;

endpackage

// File: rtl/oam_dma.sv
// rtl/oam_dma.sv - sprite DMA: copies one 256-byte PRG page into OAM while the CPU is halted
module oam_dma
    import dendy_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic        ce,
    input  logic [15:0] cpu_a,
    input  logic [7:0]  cpu_o,
    input  logic        cpu_w,
    input  logic [7:0]  oam_base,
    output logic        halt,
    output logic        busy,
    output logic [15:0] prga,
    input  logic [7:0]  prgi,
    output logic [7:0]  oama,
    output logic [7:0]  oamd,
    output logic        oamw
);

    localparam logic [7:0] LAST_IDX = 8'(OAM_SIZE - 1);

    dma_state_e state_q, state_d;
    logic [7:0] page_q, page_d;
    logic [7:0] idx_q, idx_d;
    logic [7:0] buf_q, buf_d;
    logic       odd_q, odd_d;

    always_comb begin
        state_d = state_q;
        page_d  = page_q;
        idx_d   = idx_q;
        buf_d   = buf_q;
        odd_d   = odd_q;
        if (ce) begin
            // Parity tracks every CPU cycle so the alignment stall can be decided at HALT.
            odd_d = ~odd_q;
            case (state_q)
                IDLE: begin
                    if (cpu_w && (cpu_a == DMA_REG)) begin
                        page_d  = cpu_o;
                        idx_d   = 8'd0;
                        state_d = HALT;
                    end
                end
                HALT:  state_d = odd_q ? ALIGN : RD;
                ALIGN: state_d = RD;
                RD: begin
                    buf_d   = prgi;
                    state_d = WR;
                end
                WR: begin
                    idx_d   = idx_q + 8'd1;
                    state_d = (idx_q == LAST_IDX) ? IDLE : RD;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            page_q  <= 8'd0;
            idx_q   <= 8'd0;
            buf_q   <= 8'd0;
            odd_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            page_q  <= page_d;
            idx_q   <= idx_d;
            buf_q   <= buf_d;
            odd_q   <= odd_d;
        end
    end

    // Outputs are decoded from the registered state so they hold steady across a CPU cycle.
    always_comb begin
        halt = (state_q != IDLE);
        busy = halt;
        prga = (state_q == RD) ? {page_q, idx_q} : 16'h0000;
        oama = (state_q == WR) ? (oam_base + idx_q) : 8'd0;
        oamd = (state_q == WR) ? buf_q : 8'd0;
        oamw = (state_q == WR) && ce && !reset;
    end

endmodule

// File: tb/tb_oam_dma.sv
// tb/tb_oam_dma.sv - self-checking bench for oam_dma with table vectors and random transfers
module tb_oam_dma;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        ce = 1'b0;
    logic [15:0] cpu_a = 16'h0000;
    logic [7:0]  cpu_o = 8'h00;
    logic        cpu_w = 1'b0;
    logic [7:0]  oam_base = 8'h00;
    logic        halt, busy, oamw;
    logic [15:0] prga;
    logic [7:0]  prgi = 8'h00;
    logic [7:0]  oama, oamd;

    oam_dma dut (
        .clock(clock), .reset(reset), .ce(ce), .cpu_a(cpu_a), .cpu_o(cpu_o),
        .cpu_w(cpu_w), .oam_base(oam_base), .halt(halt), .busy(busy),
        .prga(prga), .prgi(prgi), .oama(oama), .oamd(oamd), .oamw(oamw)
    );

    always #5 clock = ~clock;

    int tests = 0;
    int fails = 0;
    int ce_cnt = 0;
    int halt_cnt = 0;
    int wr_cnt = 0;
    int stray_w = 0;
    logic [7:0]  oam_got [256];
    logic [15:0] reads [$];

    function automatic logic [7:0] prg_data(input logic [15:0] a);
        logic [7:0] p;
        p = a[15:8] - 8'h02;
        return a[7:0] ^ 8'h5A ^ (p * 8'h1D);
    endfunction

    always @(negedge clock) prgi = prg_data(prga);

    always @(negedge clock) begin
        if (!reset) begin
            if (oamw && !ce) stray_w++;
            if (ce) begin
                if (halt) halt_cnt++;
                if (oamw) begin
                    oam_got[oama] = oamd;
                    wr_cnt++;
                end
                if (halt && prga != 16'h0000) reads.push_back(prga);
            end
        end
    end

    task automatic check(input string name, input longint got, input longint exp);
        tests++;
        if (got != exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic cpu_cycle(input logic w, input logic [15:0] a, input logic [7:0] d);
        int period;
        period = int'($urandom_range(2, 5));
        repeat (period - 1) begin
            @(posedge clock); #1;
            ce = 1'b0;
            cpu_w = 1'b0;
        end
        @(posedge clock); #1;
        ce = 1'b1;
        cpu_w = w;
        cpu_a = a;
        cpu_o = d;
        if (!reset) ce_cnt++;
    endtask

    task automatic run_transfer(input string name, input logic [7:0] page, input logic [7:0] base,
                                input bit want_odd, input bit busy_w, input int exp_len,
                                input logic [15:0] src00, input logic [15:0] srcff);
        int t, n, bad, rbad;
        bit done;
        oam_base = base;
        while (((ce_cnt + 1) % 2) != int'(want_odd)) cpu_cycle(1'b0, 16'h0000, 8'h00);
        for (int i = 0; i < 256; i++) oam_got[i] = 8'hxx;
        reads.delete();
        t = ce_cnt;
        cpu_cycle(1'b1, 16'h4014, page);
        halt_cnt = 0;
        wr_cnt = 0;
        done = 0;
        for (n = 1; n < 700 && !done; n++) begin
            cpu_cycle(busy_w && n == 100, 16'h4014, 8'h07);
            if (!halt) done = 1;
        end
        cpu_cycle(1'b0, 16'h0000, 8'h00);
        check({name, " finished"}, done, 1);
        check({name, " halt_len_table"}, halt_cnt, exp_len);
        check({name, " halt_len_model"}, halt_cnt, 513 + ((t + 1) % 2));
        check({name, " oamw_count"}, wr_cnt, 256);
        bad = 0;
        for (int i = 0; i < 256; i++)
            if (oam_got[(int'(base) + i) % 256] !== prg_data({page, 8'(i)})) bad++;
        check({name, " oam_bytes_bad"}, bad, 0);
        check({name, " oam00"}, oam_got[0], prg_data(src00));
        check({name, " oamff"}, oam_got[255], prg_data(srcff));
        rbad = 0;
        if (reads.size() != 256) rbad = 1000;
        else for (int i = 0; i < 256; i++) if (reads[i] != {page, 8'(i)}) rbad++;
        check({name, " prg_reads_bad"}, rbad, 0);
        check({name, " busy_idle"}, busy, 0);
    endtask

    typedef struct {
        logic [7:0]  page;
        logic [7:0]  base;
        bit          want_odd;
        bit          busy_w;
        int          exp_len;
        logic [15:0] src00;
        logic [15:0] srcff;
    } vec_t;

    initial begin
        vec_t vt [5];
        int snap, bad;
        vt[0] = '{8'h02, 8'h00, 1'b0, 1'b0, 513, 16'h0200, 16'h02FF};
        vt[1] = '{8'h02, 8'h00, 1'b1, 1'b0, 514, 16'h0200, 16'h02FF};
        vt[2] = '{8'h03, 8'hF0, 1'b0, 1'b0, 513, 16'h0310, 16'h030F};
        vt[3] = '{8'h02, 8'h00, 1'b0, 1'b1, 513, 16'h0200, 16'h02FF};
        vt[4] = '{8'hFF, 8'h10, 1'b1, 1'b0, 514, 16'hFFF0, 16'hFFEF};

        repeat (3) @(posedge clock);
        #1;
        check("reset halt", halt, 0);
        check("reset busy", busy, 0);
        check("reset prga", prga, 0);
        check("reset oama", oama, 0);
        check("reset oamd", oamd, 0);
        check("reset oamw", oamw, 0);
        reset = 1'b0;
        ce_cnt = 0;

        bad = 0;
        for (int k = 0; k < 8; k++) begin
            @(posedge clock); #1;
            ce = 1'b0;
            cpu_w = 1'b1;
            cpu_a = 16'h4014;
            cpu_o = 8'h55;
            if (halt) bad++;
        end
        cpu_w = 1'b0;
        repeat (4) begin
            cpu_cycle(1'b0, 16'h0000, 8'h00);
            if (halt || busy) bad++;
        end
        cpu_cycle(1'b1, 16'h4015, 8'h02);
        cpu_cycle(1'b0, 16'h0000, 8'h00);
        if (halt) bad++;
        check("no_trigger_halt_seen", bad, 0);

        for (int v = 0; v < 5; v++)
            run_transfer($sformatf("vec%0d", v), vt[v].page, vt[v].base, vt[v].want_odd,
                         vt[v].busy_w, vt[v].exp_len, vt[v].src00, vt[v].srcff);

        for (int r = 0; r < 3; r++) begin
            logic [7:0] pg, bs;
            bit od;
            pg = 8'($urandom_range(1, 255));
            bs = 8'($urandom_range(0, 255));
            od = 1'($urandom_range(0, 1));
            run_transfer($sformatf("rnd%0d", r), pg, bs, od, 1'b0, od ? 514 : 513,
                         {pg, 8'(8'h00 - bs)}, {pg, 8'(8'hFF - bs)});
        end

        oam_base = 8'h00;
        wr_cnt = 0;
        cpu_cycle(1'b1, 16'h4014, 8'h02);
        for (int n = 0; n < 200 && wr_cnt < 40; n++) cpu_cycle(1'b0, 16'h0000, 8'h00);
        snap = wr_cnt;
        check("reset_mid writes_before", snap, 40);
        @(posedge clock); #1;
        reset = 1'b1;
        ce = 1'b1;
        cpu_w = 1'b1;
        cpu_a = 16'h4014;
        cpu_o = 8'h09;
        @(posedge clock); #1;
        check("reset_mid halt_next_clock", halt, 0);
        check("reset_mid oamw_in_reset", oamw, 0);
        ce = 1'b0;
        cpu_w = 1'b0;
        reset = 1'b0;
        ce_cnt = 0;
        repeat (20) cpu_cycle(1'b0, 16'h0000, 8'h00);
        check("reset_mid no_more_writes", wr_cnt, snap);
        check("reset_mid halt_idle", halt, 0);
        run_transfer("after_reset", 8'h02, 8'h00, 1'b0, 1'b0, 513, 16'h0200, 16'h02FF);

        check("stray_oamw", stray_w, 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
